// File: rtl/mfp_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// mfp_ahb_arbiter
//
// Two-master AHB-lite arbiter that sits in front of mfp_ahb. It lets a second
// bus master (DMA engine or debug loader) share the slave fabric with the
// MIPS core. Each master port has a one-entry address-phase holding register.
// A master that loses arbitration has its address phase parked there and is
// stalled through its own HREADY, in the same way as an AHB multilayer input
// stage. Grant is round-robin, with a bounded hold for SEQ bursts.
//
// Parameters:
//   HOLD_MAX      - consecutive accepted SEQ transfers an owner may keep the
//                   grant while the other master waits (1..15)
//
// Ports:
//   HCLK, HRESET  - bus clock, asynchronous active-high reset
//   *_M0 / *_M1   - master-side address phase, write data, ready, response
//   HRDATA_M      - read data returned to both masters
//   HADDR..HWDATA - slave-side address phase and write data (to mfp_ahb)
//   HRDATA, HREADY, HRESP - slave-side response (from mfp_ahb)
//   GRANT         - current address-phase owner (debug only)
//
// Optional feature:
//   MFP_AHB_ARB_LOCK_EN - when defined, a transfer accepted with HMASTLOCK=1
//                   pins the grant to its master until that master drops the
//                   lock. When undefined, HMASTLOCK is only forwarded.
// ---------------------------------------------------------------------------
module mfp_ahb_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,

    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [2:0]  HBURST_M0,
    input  logic [3:0]  HPROT_M0,
    input  logic        HMASTLOCK_M0,
    input  logic [31:0] HWDATA_M0,
    output logic        HREADY_M0,
    output logic        HRESP_M0,

    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [2:0]  HBURST_M1,
    input  logic [3:0]  HPROT_M1,
    input  logic        HMASTLOCK_M1,
    input  logic [31:0] HWDATA_M1,
    output logic        HREADY_M1,
    output logic        HRESP_M1,

    output logic [31:0] HRDATA_M,

    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,

    output logic        GRANT
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;
    localparam logic [3:0] HOLD_LIMIT  = 4'(HOLD_MAX);

    // Live master address phases, gathered into arrays indexed by master
    logic [31:0] live_addr  [2];
    logic [1:0]  live_trans [2];
    logic        live_write [2];
    logic [2:0]  live_size  [2];
    logic [2:0]  live_burst [2];
    logic [3:0]  live_prot  [2];
    logic        live_lock  [2];

    // One-entry holding registers
    logic        pend_valid [2];
    logic [31:0] pend_addr  [2];
    logic [1:0]  pend_trans [2];
    logic        pend_write [2];
    logic [2:0]  pend_size  [2];
    logic [2:0]  pend_burst [2];
    logic [3:0]  pend_prot  [2];
    logic        pend_lock  [2];

    // Per-master request source: the holding register wins over live inputs
    logic [31:0] src_addr  [2];
    logic [1:0]  src_trans [2];
    logic        src_write [2];
    logic [2:0]  src_size  [2];
    logic [2:0]  src_burst [2];
    logic [3:0]  src_prot  [2];
    logic        src_lock  [2];

    logic [1:0]  hready_m;
    logic [1:0]  live_req;
    logic [1:0]  req;

    logic        grant_q;
    logic        grant;
    logic        arb_pick;
    logic        accept;
    logic        last;
    logic [3:0]  hold_cnt;
    logic        dvalid;
    logic        downer;

    assign live_addr[0]  = HADDR_M0;
    assign live_addr[1]  = HADDR_M1;
    assign live_trans[0] = HTRANS_M0;
    assign live_trans[1] = HTRANS_M1;
    assign live_write[0] = HWRITE_M0;
    assign live_write[1] = HWRITE_M1;
    assign live_size[0]  = HSIZE_M0;
    assign live_size[1]  = HSIZE_M1;
    assign live_burst[0] = HBURST_M0;
    assign live_burst[1] = HBURST_M1;
    assign live_prot[0]  = HPROT_M0;
    assign live_prot[1]  = HPROT_M1;
    assign live_lock[0]  = HMASTLOCK_M0;
    assign live_lock[1]  = HMASTLOCK_M1;

    // Per-master ready, request and source selection. A master in its data
    // phase follows the slave's HREADY. Any other master is stalled only
    // while it has a parked address. A live address counts as a request only
    // while that master's own HREADY is high, which guarantees that a parked
    // master never has a second transfer captured.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src_addr[i]  = pend_valid[i] ? pend_addr[i]  : live_addr[i];
            src_trans[i] = pend_valid[i] ? pend_trans[i] : live_trans[i];
            src_write[i] = pend_valid[i] ? pend_write[i] : live_write[i];
            src_size[i]  = pend_valid[i] ? pend_size[i]  : live_size[i];
            src_burst[i] = pend_valid[i] ? pend_burst[i] : live_burst[i];
            src_prot[i]  = pend_valid[i] ? pend_prot[i]  : live_prot[i];
            src_lock[i]  = pend_valid[i] ? pend_lock[i]  : live_lock[i];
            hready_m[i]  = (dvalid && downer == 1'(i)) ? HREADY : !pend_valid[i];
            live_req[i]  = hready_m[i] && live_trans[i][1];
            req[i]       = pend_valid[i] || live_req[i];
        end
    end

    // Round-robin choice. A sole requester wins. On a tie, an owner in the
    // middle of a SEQ burst keeps the bus until it has used up its hold
    // budget; otherwise the master that was not accepted last goes next.
    always_comb begin
        arb_pick = grant_q;
        case (req)
            2'b01:   arb_pick = 1'b0;
            2'b10:   arb_pick = 1'b1;
            2'b11: begin
                if (src_trans[grant_q] == HTRANS_SEQ && hold_cnt < HOLD_LIMIT)
                    arb_pick = grant_q;
                else
                    arb_pick = ~last;
            end
            default: arb_pick = grant_q;
        endcase
    end

`ifdef MFP_AHB_ARB_LOCK_EN
    logic lock_q;
    logic lock_owner;

    // Locked-sequence tracking. An accepted transfer copies its HMASTLOCK
    // into lock_q. An owner that goes idle with the lock dropped also
    // releases the bus, so a locked sequence can end on an IDLE cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            lock_q     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (accept) begin
            lock_q     <= src_lock[grant];
            lock_owner <= grant;
        end else if (HREADY && lock_q && !req[lock_owner] && !live_lock[lock_owner]) begin
            lock_q     <= 1'b0;
        end
    end

    assign grant = !HREADY ? grant_q : (lock_q ? lock_owner : arb_pick);
`else
    assign grant = HREADY ? arb_pick : grant_q;
`endif

    assign accept = HREADY && req[grant];

    // Grant, data-phase and hold bookkeeping. The grant only moves while the
    // slave is ready, so the slave-side address phase stays stable through
    // wait states. hold_cnt counts SEQ beats accepted back-to-back from the
    // same master and restarts on NONSEQ or on a hand-over.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_q  <= 1'b0;
            last     <= 1'b1;
            hold_cnt <= 4'd0;
            dvalid   <= 1'b0;
            downer   <= 1'b0;
        end else begin
            if (HREADY) begin
                grant_q <= grant;
                dvalid  <= accept;
                if (accept)
                    downer <= grant;
            end
            if (accept) begin
                last <= grant;
                if (grant != last || src_trans[grant] != HTRANS_SEQ)
                    hold_cnt <= 4'd0;
                else if (hold_cnt != 4'hF)
                    hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    // Holding registers. A live request that is not accepted in its cycle is
    // parked here. The master saw HREADY high, so from its point of view the
    // address phase is already complete. The entry empties when accepted.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < 2; i++) begin
                pend_valid[i] <= 1'b0;
                pend_addr[i]  <= '0;
                pend_trans[i] <= HTRANS_IDLE;
                pend_write[i] <= 1'b0;
                pend_size[i]  <= '0;
                pend_burst[i] <= '0;
                pend_prot[i]  <= '0;
                pend_lock[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept && grant == 1'(i)) begin
                    pend_valid[i] <= 1'b0;
                end else if (live_req[i] && !pend_valid[i]) begin
                    pend_valid[i] <= 1'b1;
                    pend_addr[i]  <= live_addr[i];
                    pend_trans[i] <= live_trans[i];
                    pend_write[i] <= live_write[i];
                    pend_size[i]  <= live_size[i];
                    pend_burst[i] <= live_burst[i];
                    pend_prot[i]  <= live_prot[i];
                    pend_lock[i]  <= live_lock[i];
                end
            end
        end
    end

    // Slave side follows the granted master. HTRANS is IDLE when that master
    // has nothing to offer.
    assign HADDR     = src_addr[grant];
    assign HTRANS    = req[grant] ? src_trans[grant] : HTRANS_IDLE;
    assign HWRITE    = src_write[grant];
    assign HSIZE     = src_size[grant];
    assign HBURST    = src_burst[grant];
    assign HPROT     = src_prot[grant];
    assign HMASTLOCK = src_lock[grant];
    assign HWDATA    = downer ? HWDATA_M1 : HWDATA_M0;
    assign GRANT     = grant;

    assign HREADY_M0 = hready_m[0];
    assign HREADY_M1 = hready_m[1];
    assign HRESP_M0  = (dvalid && downer == 1'b0) ? HRESP : 1'b0;
    assign HRESP_M1  = (dvalid && downer == 1'b1) ? HRESP : 1'b0;
    assign HRDATA_M  = HRDATA;

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_arbiter
//
// Directed testbench for mfp_ahb_arbiter. Each scenario task drives
// cycle-by-cycle master and slave stimulus and compares the arbiter outputs
// against hand-computed values. Inputs change 1 ns after the rising edge.
// Outputs are compared 2 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR_M0, HADDR_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1;
    logic [2:0]  HBURST_M0, HBURST_M1;
    logic [3:0]  HPROT_M0, HPROT_M1;
    logic        HMASTLOCK_M0, HMASTLOCK_M1;
    logic [31:0] HWDATA_M0, HWDATA_M1;
    logic        HREADY_M0, HREADY_M1;
    logic        HRESP_M0, HRESP_M1;
    logic [31:0] HRDATA_M;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        GRANT;

    int checks = 0;
    int errors = 0;

    mfp_ahb_arbiter #(.HOLD_MAX(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
        .HSIZE_M0(HSIZE_M0), .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0),
        .HMASTLOCK_M0(HMASTLOCK_M0), .HWDATA_M0(HWDATA_M0),
        .HREADY_M0(HREADY_M0), .HRESP_M0(HRESP_M0),
        .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M1(HSIZE_M1), .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1),
        .HMASTLOCK_M1(HMASTLOCK_M1), .HWDATA_M1(HWDATA_M1),
        .HREADY_M1(HREADY_M1), .HRESP_M1(HRESP_M1),
        .HRDATA_M(HRDATA_M),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .GRANT(GRANT)
    );

    // 100 MHz bus clock
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Both masters idle, slave ready with an OKAY response
    task automatic idle_all();
        HADDR_M0 = '0; HTRANS_M0 = IDLE; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'b010;
        HBURST_M0 = 3'b000; HPROT_M0 = 4'b0011; HMASTLOCK_M0 = 1'b0; HWDATA_M0 = '0;
        HADDR_M1 = '0; HTRANS_M1 = IDLE; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'b010;
        HBURST_M1 = 3'b000; HPROT_M1 = 4'b0011; HMASTLOCK_M1 = 1'b0; HWDATA_M1 = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        HRESET = 1'b1;
        step();
        step();
        HRESET = 1'b0;
    endtask

    // Reset values of the visible outputs
    task automatic test_reset();
        do_reset();
        #2;
        checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_hready_m0: got %b expected 1", HREADY_M0); end
        checks++; if (HREADY_M1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_hready_m1: got %b expected 1", HREADY_M1); end
        checks++; if (HTRANS !== IDLE) begin errors++; $display("[TB] FAIL reset_htrans: got %b expected 00", HTRANS); end
        checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0", GRANT); end
        checks++; if (HRESP_M0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_hresp_m0: got %b expected 0", HRESP_M0); end
        step();
    endtask

    // Both masters issue NONSEQ together: M0 wins the first tie, M1 is parked
    task automatic test_simultaneous();
        do_reset();
        HADDR_M0 = 32'hBF80_0000; HTRANS_M0 = NONSEQ; HWRITE_M0 = 1'b0; HWDATA_M0 = 32'h1111_1111;
        HADDR_M1 = 32'h8000_0010; HTRANS_M1 = NONSEQ; HWRITE_M1 = 1'b1; HWDATA_M1 = 32'hCAFE_0001;
        #2;
        checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL sim_c0_grant: got %b expected 0", GRANT); end
        checks++; if (HADDR !== 32'hBF80_0000) begin errors++; $display("[TB] FAIL sim_c0_haddr: got %h expected bf800000", HADDR); end
        checks++; if (HTRANS !== NONSEQ) begin errors++; $display("[TB] FAIL sim_c0_htrans: got %b expected 10", HTRANS); end
        checks++; if (HWRITE !== 1'b0) begin errors++; $display("[TB] FAIL sim_c0_hwrite: got %b expected 0", HWRITE); end
        checks++; if (HREADY_M1 !== 1'b1) begin errors++; $display("[TB] FAIL sim_c0_hready_m1: got %b expected 1", HREADY_M1); end
        step();
        // Cycle 1: both masters move on to IDLE; M1's data is held
        HTRANS_M0 = IDLE; HTRANS_M1 = IDLE; HRDATA = 32'h5A5A_0F0F;
        #2;
        checks++; if (HREADY_M1 !== 1'b0) begin errors++; $display("[TB] FAIL sim_c1_hready_m1: got %b expected 0", HREADY_M1); end
        checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("[TB] FAIL sim_c1_hready_m0: got %b expected 1", HREADY_M0); end
        checks++; if (GRANT !== 1'b1) begin errors++; $display("[TB] FAIL sim_c1_grant: got %b expected 1", GRANT); end
        checks++; if (HADDR !== 32'h8000_0010) begin errors++; $display("[TB] FAIL sim_c1_haddr: got %h expected 80000010", HADDR); end
        checks++; if (HWRITE !== 1'b1) begin errors++; $display("[TB] FAIL sim_c1_hwrite: got %b expected 1", HWRITE); end
        checks++; if (HRDATA_M !== 32'h5A5A_0F0F) begin errors++; $display("[TB] FAIL sim_c1_hrdata: got %h expected 5a5a0f0f", HRDATA_M); end
        step();
        #2;
        checks++; if (HREADY_M1 !== 1'b1) begin errors++; $display("[TB] FAIL sim_c2_hready_m1: got %b expected 1", HREADY_M1); end
        checks++; if (HWDATA !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL sim_c2_hwdata: got %h expected cafe0001", HWDATA); end
        checks++; if (HTRANS !== IDLE) begin errors++; $display("[TB] FAIL sim_c2_htrans: got %b expected 00", HTRANS); end
        step();
    endtask

    // M1 runs an INCR8 burst while M0 requests continuously
    task automatic test_burst_hold();
        logic [31:0] base;
        logic [31:0] exp_addr;
        base = 32'h8000_0200;
        do_reset();
        HADDR_M1 = base; HTRANS_M1 = NONSEQ; HBURST_M1 = 3'b101; HSIZE_M1 = 3'b010;
        #2;
        checks++; if (GRANT !== 1'b1) begin errors++; $display("[TB] FAIL burst_c0_grant: got %b expected 1", GRANT); end
        checks++; if (HTRANS !== NONSEQ) begin errors++; $display("[TB] FAIL burst_c0_htrans: got %b expected 10", HTRANS); end
        step();
        HADDR_M0 = 32'h8000_0300; HTRANS_M0 = NONSEQ;
        for (int k = 1; k <= 4; k++) begin
            exp_addr = base + 32'(4 * k);
            HADDR_M1 = exp_addr; HTRANS_M1 = SEQ;
            #2;
            checks++; if (GRANT !== 1'b1) begin errors++; $display("[TB] FAIL burst_seq%0d_grant: got %b expected 1", k, GRANT); end
            checks++; if (HADDR !== exp_addr) begin errors++; $display("[TB] FAIL burst_seq%0d_haddr: got %h expected %h", k, HADDR, exp_addr); end
            checks++; if (HREADY_M0 !== (k == 1)) begin errors++; $display("[TB] FAIL burst_seq%0d_hready_m0: got %b expected %b", k, HREADY_M0, (k == 1)); end
            step();
        end
        // Hold budget used up: M0's parked NONSEQ goes next
        HADDR_M1 = base + 32'd20;
        #2;
        checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL burst_c5_grant: got %b expected 0", GRANT); end
        checks++; if (HADDR !== 32'h8000_0300) begin errors++; $display("[TB] FAIL burst_c5_haddr: got %h expected 80000300", HADDR); end
        checks++; if (HTRANS !== NONSEQ) begin errors++; $display("[TB] FAIL burst_c5_htrans: got %b expected 10", HTRANS); end
        step();
        // M1 resumes from its parked beat, not from its newer live address
        HADDR_M1 = base + 32'd24;
        #2;
        checks++; if (GRANT !== 1'b1) begin errors++; $display("[TB] FAIL burst_c6_grant: got %b expected 1", GRANT); end
        checks++; if (HADDR !== base + 32'd20) begin errors++; $display("[TB] FAIL burst_c6_haddr: got %h expected %h", HADDR, base + 32'd20); end
        checks++; if (HTRANS !== SEQ) begin errors++; $display("[TB] FAIL burst_c6_htrans: got %b expected 11", HTRANS); end
        checks++; if (HREADY_M1 !== 1'b0) begin errors++; $display("[TB] FAIL burst_c6_hready_m1: got %b expected 0", HREADY_M1); end
        step();
    endtask

    // Three slave wait states during M0's data phase while M1 arrives
    task automatic test_wait_state();
        do_reset();
        HADDR_M0 = 32'h8000_0400; HTRANS_M0 = NONSEQ;
        step();
        HADDR_M0 = 32'h8000_0404; HREADY = 1'b0;
        HADDR_M1 = 32'h8000_0800; HTRANS_M1 = NONSEQ; HWRITE_M1 = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            #2;
            checks++; if (HADDR !== 32'h8000_0404) begin errors++; $display("[TB] FAIL wait%0d_haddr: got %h expected 80000404", w, HADDR); end
            checks++; if (HREADY_M0 !== 1'b0) begin errors++; $display("[TB] FAIL wait%0d_hready_m0: got %b expected 0", w, HREADY_M0); end
            checks++; if (HREADY_M1 !== (w == 1)) begin errors++; $display("[TB] FAIL wait%0d_hready_m1: got %b expected %b", w, HREADY_M1, (w == 1)); end
            step();
            HTRANS_M1 = IDLE;
        end
        HREADY = 1'b1;
        #2;
        checks++; if (GRANT !== 1'b1) begin errors++; $display("[TB] FAIL wait_end_grant: got %b expected 1", GRANT); end
        checks++; if (HADDR !== 32'h8000_0800) begin errors++; $display("[TB] FAIL wait_end_haddr: got %h expected 80000800", HADDR); end
        checks++; if (HWRITE !== 1'b1) begin errors++; $display("[TB] FAIL wait_end_hwrite: got %b expected 1", HWRITE); end
        step();
    endtask

    // Locked read-modify-write from M0 while M1 keeps requesting
    task automatic test_locked();
        do_reset();
        HADDR_M0 = 32'h8000_0000; HTRANS_M0 = NONSEQ; HWRITE_M0 = 1'b0; HMASTLOCK_M0 = 1'b1;
        HADDR_M1 = 32'h8000_0040; HTRANS_M1 = NONSEQ; HWRITE_M1 = 1'b1;
        #2;
        checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL lock_c0_grant: got %b expected 0", GRANT); end
        checks++; if (HMASTLOCK !== 1'b1) begin errors++; $display("[TB] FAIL lock_c0_hmastlock: got %b expected 1", HMASTLOCK); end
        step();
        HWRITE_M0 = 1'b1; HTRANS_M1 = IDLE;
        #2;
`ifdef MFP_AHB_ARB_LOCK_EN
        checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL lock_c1_grant: got %b expected 0", GRANT); end
        checks++; if (HADDR !== 32'h8000_0000) begin errors++; $display("[TB] FAIL lock_c1_haddr: got %h expected 80000000", HADDR); end
        checks++; if (HWRITE !== 1'b1) begin errors++; $display("[TB] FAIL lock_c1_hwrite: got %b expected 1", HWRITE); end
`else
        checks++; if (GRANT !== 1'b1) begin errors++; $display("[TB] FAIL lock_c1_grant: got %b expected 1", GRANT); end
        checks++; if (HADDR !== 32'h8000_0040) begin errors++; $display("[TB] FAIL lock_c1_haddr: got %h expected 80000040", HADDR); end
`endif
        step();
        HTRANS_M0 = IDLE; HMASTLOCK_M0 = 1'b0; HWRITE_M0 = 1'b0;
        #2;
`ifdef MFP_AHB_ARB_LOCK_EN
        checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL lock_c2_grant: got %b expected 0", GRANT); end
        checks++; if (HTRANS !== IDLE) begin errors++; $display("[TB] FAIL lock_c2_htrans: got %b expected 00", HTRANS); end
        checks++; if (HREADY_M1 !== 1'b0) begin errors++; $display("[TB] FAIL lock_c2_hready_m1: got %b expected 0", HREADY_M1); end
        step();
        #2;
        checks++; if (GRANT !== 1'b1) begin errors++; $display("[TB] FAIL lock_c3_grant: got %b expected 1", GRANT); end
        checks++; if (HADDR !== 32'h8000_0040) begin errors++; $display("[TB] FAIL lock_c3_haddr: got %h expected 80000040", HADDR); end
`else
        checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL lock_c2_grant: got %b expected 0", GRANT); end
        checks++; if (HADDR !== 32'h8000_0000) begin errors++; $display("[TB] FAIL lock_c2_haddr: got %h expected 80000000", HADDR); end
        checks++; if (HWRITE !== 1'b1) begin errors++; $display("[TB] FAIL lock_c2_hwrite: got %b expected 1", HWRITE); end
        checks++; if (HMASTLOCK !== 1'b1) begin errors++; $display("[TB] FAIL lock_c2_hmastlock: got %b expected 1", HMASTLOCK); end
`endif
        step();
    endtask

    // Reset pulse while M0 is in a stalled data phase and M1 is parked
    task automatic test_reset_mid();
        do_reset();
        HADDR_M0 = 32'h8000_0500; HTRANS_M0 = NONSEQ;
        HADDR_M1 = 32'h8000_0600; HTRANS_M1 = NONSEQ; HWRITE_M1 = 1'b1;
        step();
        HTRANS_M0 = IDLE; HTRANS_M1 = IDLE; HREADY = 1'b0; HRESP = 1'b1;
        #2;
        checks++; if (HREADY_M0 !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pre_hready_m0: got %b expected 0", HREADY_M0); end
        checks++; if (HREADY_M1 !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pre_hready_m1: got %b expected 0", HREADY_M1); end
        checks++; if (HRESP_M0 !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre_hresp_m0: got %b expected 1", HRESP_M0); end
        checks++; if (HRESP_M1 !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pre_hresp_m1: got %b expected 0", HRESP_M1); end
        HRESET = 1'b1;
        #1;
        checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("[TB] FAIL rmid_rst_hready_m0: got %b expected 1", HREADY_M0); end
        checks++; if (HREADY_M1 !== 1'b1) begin errors++; $display("[TB] FAIL rmid_rst_hready_m1: got %b expected 1", HREADY_M1); end
        checks++; if (HRESP_M0 !== 1'b0) begin errors++; $display("[TB] FAIL rmid_rst_hresp_m0: got %b expected 0", HRESP_M0); end
        checks++; if (HTRANS !== IDLE) begin errors++; $display("[TB] FAIL rmid_rst_htrans: got %b expected 00", HTRANS); end
        step();
        HRESET = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            checks++; if (HTRANS !== IDLE) begin errors++; $display("[TB] FAIL rmid_post%0d_htrans: got %b expected 00", c, HTRANS); end
            checks++; if (GRANT !== 1'b0) begin errors++; $display("[TB] FAIL rmid_post%0d_grant: got %b expected 0", c, GRANT); end
            step();
        end
    endtask

    initial begin
        HRESET = 1'b1;
        idle_all();
        test_reset();
        test_simultaneous();
        test_burst_hold();
        test_wait_state();
        test_locked();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_arbiter.md
# mfp_ahb_arbiter

Two-master AHB-lite arbiter placed in front of `mfp_ahb`, so a second bus master (DMA or debug loader) shares the slave fabric (boot RAM, program RAM, GPIO, 7-segment display) with the MIPS core. Each master port has a one-entry address-phase holding register, so a master that loses arbitration is stalled through its own `HREADY`, as in an AHB multilayer input stage. Grant uses round-robin with bounded burst hold and optional locked-transfer support.

## Interface
- `HOLD_MAX`, 4: maximum consecutive accepted SEQ transfers an owner keeps the grant while the other master waits; range 1–15.
- `HCLK` in 1: bus clock.
- `HRESET` in 1: asynchronous, active-high reset.
- `HADDR_M0` / `HADDR_M1` in 32: master address.
- `HTRANS_M0` / `HTRANS_M1` in 2: transfer type; bit1 = 1 means request.
- `HWRITE_M0` / `HWRITE_M1` in 1; `HSIZE_M0` / `HSIZE_M1` in 3; `HBURST_M0` / `HBURST_M1` in 3; `HPROT_M0` / `HPROT_M1` in 4; `HMASTLOCK_M0` / `HMASTLOCK_M1` in 1: address-phase controls.
- `HWDATA_M0` / `HWDATA_M1` in 32: write data, valid in the data phase.
- `HREADY_M0` / `HREADY_M1` out 1: per-master ready.
- `HRESP_M0` / `HRESP_M1` out 1: per-master response.
- `HRDATA_M` out 32: read data, common to both masters.
- `HADDR`, `HTRANS`, `HWRITE`, `HSIZE`, `HBURST`, `HPROT`, `HMASTLOCK`, `HWDATA` out: slave side, same widths as the master ports; drive `mfp_ahb`.
- `HRDATA` in 32, `HREADY` in 1, `HRESP` in 1: from `mfp_ahb`.
- `GRANT` out 1: current address-phase owner; debug only.

## Operation
- **Request:** `req_X = pend_X | (HREADY_MX & HTRANS_MX[1])`.
- **Accept:** master X's transfer is accepted when X is granted and `HREADY == 1`.
- **Capture:** a live request with `HREADY_MX == 1` that is not accepted in that cycle is captured into `pend_X` (address plus all controls).
- **Slave-side source:** the slave side drives the granted master's `pend_X` if valid, otherwise its live signals. When there is no request, the slave side drives `HTRANS = IDLE` (2'b00).
- **Data phase:** register `dvalid` / `downer` is loaded on accept (`dvalid = 1`, `downer = X`). When `HREADY == 1`, it is either reloaded by the next accept or cleared.
- **HWDATA:** muxed by `downer`.
- **HREADY_MX:** equals `HREADY` if `dvalid && downer == X`; otherwise equals `!pend_X`.
- **HRESP_MX:** equals `HRESP` if `downer == X && dvalid`; otherwise 0.
- **HRDATA_M:** equals `HRDATA`.
- **Arbitration:** evaluated only when `HREADY == 1`. While `HREADY == 0`, the grant is frozen.
  - If exactly one master requests, that master is granted.
  - If both request, the current owner keeps the grant when its request is SEQ and `hold_cnt < HOLD_MAX`. Otherwise the grant goes to the master that was not `last`.
- **Bookkeeping on accept:**
  - `last` is set to the accepted master.
  - `hold_cnt` increments on each accepted SEQ transfer and resets to 0 on any accepted NONSEQ or on a change of owner.
  - `pend_X` clears when its transfer is accepted.

## Timing
- **Reset values:**
  - `pend_M0 = pend_M1 = 0`, `dvalid = 0`, `last = 1` (M0 wins the first tie), `hold_cnt = 0`, `lock_q = 0`.
  - Outputs: `HREADY_M0 = HREADY_M1 = 1`, `HRESP_M* = 0`, `HTRANS = IDLE`, `GRANT = 0`.
- **Latency:**
  - An uncontested request is accepted in the same cycle; the address path is combinational, with zero added latency.
  - A losing master sees `HREADY_MX = 0` from the cycle after capture until its data phase completes, a minimum 1-cycle penalty.
- **Slave stalls:** while `HREADY == 0`, `pend_X` is held, the slave-side address and controls are stable, and new live requests are not sampled because `HREADY_MX` is 0 for a master that is in a data phase or has a pending entry.
- **Capture rule:** a master with a pending entry never has a second transfer captured.
- **Simultaneous events:** data-phase completion for X and a new live address from X in the same cycle → the new address is accepted or captured, never lost.
- **Reset mid-transfer:** all pending entries and the data phase are dropped immediately; outputs return to their reset values asynchronously.

## Configuration
- **`MFP_AHB_ARB_LOCK_EN` defined:**
  - `lock_q` / `lock_owner` are set when an accepted transfer carries `HMASTLOCK = 1`.
  - While `lock_q` is set, only `lock_owner` may be granted; the other master is captured and waits.
  - `lock_q` clears when the owner's next accepted transfer, or an IDLE cycle from the owner, has `HMASTLOCK = 0`.
  - Locked grants ignore `HOLD_MAX`.
- **Not defined:** `HMASTLOCK_M*` is ignored for arbitration but still forwarded to `HMASTLOCK`.

## Test plan
- **Reset:** assert `HRESET` → `HREADY_M0 = HREADY_M1 = 1`, `HTRANS = IDLE`, `GRANT = 0`.
- **Simultaneous NONSEQ:**
  - Stimulus: M0 NONSEQ read 0xBF800000 and M1 NONSEQ write 0x80000010 in the same cycle, `HREADY = 1`.
  - Required: M0 is accepted in cycle 0. M1 is captured; `HREADY_M1` is 0 in cycle 1 and 1 in cycle 2 after its accept in cycle 1. `HWDATA` carries M1's data in cycle 2.
- **Burst hold:**
  - Stimulus: M1 INCR8 SEQ burst while M0 requests continuously, `HOLD_MAX = 4`.
  - Required: M1 keeps the grant for NONSEQ + 4 SEQ, then M0 is granted. M1 resumes from `pend_M1` with the correct next address.
- **Slave wait state:**
  - Stimulus: `HREADY` held 0 for 3 cycles during M0's data phase.
  - Required: the slave-side address is constant across all 3 cycles, `HREADY_M0 = 0`, and M1's new request is held in `pend_M1`.
- **Locked sequence (`MFP_AHB_ARB_LOCK_EN`):**
  - Stimulus: M0 issues a locked read-modify-write to 0x80000000 while M1 requests throughout.
  - Required: M1 is not granted until M0 drops `HMASTLOCK`. Without the macro, M1 interleaves between the read and the write.
- **Reset mid-data-phase:**
  - Stimulus: pulse `HRESET` while `dvalid = 1` and `pend_M1 = 1`.
  - Required: all state is cleared and no slave transfer is issued after release.
